// File: rtl/slurm_cpu_execute_hs_pkg.sv
// Shared decode package for the execute stage: instruction classes, decode
// helpers, bus FSM state encoding and ALU opcode width.
package slurm_cpu_execute_hs_pkg;

  localparam int unsigned ALU_OP_BITS   = 5;
  localparam int unsigned ALU_OP_LSB    = 7;
  localparam int unsigned INSTR_BITS    = 16;
  localparam int unsigned WAIT_CNT_BITS = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } bus_state_t;

  // Instruction classes live in the top nibble; the low 12 bits are operand fields.
  localparam logic [INSTR_BITS-1:0] INS_ALU_SINGLE = 16'b0001_????_????_????;
  localparam logic [INSTR_BITS-1:0] INS_ALU_REG    = 16'b0010_????_????_????;
  localparam logic [INSTR_BITS-1:0] INS_ALU_IMM    = 16'b0011_????_????_????;
  localparam logic [INSTR_BITS-1:0] INS_BRANCH     = 16'b0100_????_????_????;
  localparam logic [INSTR_BITS-1:0] INS_RET        = 16'b0101_????_????_????;
  localparam logic [INSTR_BITS-1:0] INS_IRET       = 16'b0110_????_????_????;
  localparam logic [INSTR_BITS-1:0] INS_LOAD       = 16'b0111_????_????_????;
  localparam logic [INSTR_BITS-1:0] INS_STORE      = 16'b1000_????_????_????;
  localparam logic [INSTR_BITS-1:0] INS_PEEK       = 16'b1001_????_????_????;
  localparam logic [INSTR_BITS-1:0] INS_POKE       = 16'b1010_????_????_????;
  localparam logic [INSTR_BITS-1:0] INS_INT_EN     = 16'b1011_????_????_????;
  localparam logic [INSTR_BITS-1:0] INS_INT_DIS    = 16'b1100_????_????_????;

  // Branch condition codes in instruction[2:0].
  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_Z      = 3'd1;
  localparam logic [2:0] COND_NZ     = 3'd2;
  localparam logic [2:0] COND_C      = 3'd3;
  localparam logic [2:0] COND_NC     = 3'd4;
  localparam logic [2:0] COND_S      = 3'd5;
  localparam logic [2:0] COND_NS     = 3'd6;

  typedef struct packed {
    logic is_alu;
    logic alu_imm;
    logic is_branch;
    logic is_ret;
    logic is_mem;
    logic mem_wr;
    logic mem_port;
    logic int_on;
    logic int_off;
  } ins_dec_t;

  function automatic ins_dec_t ins_decode(input logic [INSTR_BITS-1:0] ins);
    ins_dec_t d;
    d = '0;
    casez (ins)
      INS_ALU_SINGLE: d.is_alu = 1'b1;
      INS_ALU_REG:    d.is_alu = 1'b1;
      INS_ALU_IMM:    begin d.is_alu = 1'b1; d.alu_imm = 1'b1; end
      INS_BRANCH:     d.is_branch = 1'b1;
      INS_RET:        d.is_ret = 1'b1;
      INS_IRET:       d.is_ret = 1'b1;
      INS_LOAD:       d.is_mem = 1'b1;
      INS_STORE:      begin d.is_mem = 1'b1; d.mem_wr = 1'b1; end
      INS_PEEK:       begin d.is_mem = 1'b1; d.mem_port = 1'b1; end
      INS_POKE:       begin d.is_mem = 1'b1; d.mem_port = 1'b1; d.mem_wr = 1'b1; end
      INS_INT_EN:     d.int_on = 1'b1;
      INS_INT_DIS:    d.int_off = 1'b1;
      default:        d = '0;
    endcase
    return d;
  endfunction

  function automatic logic branch_taken(input logic [2:0] cond, input logic z,
                                        input logic c, input logic s);
    logic t;
    case (cond)
      COND_ALWAYS: t = 1'b1;
      COND_Z:      t = z;
      COND_NZ:     t = ~z;
      COND_C:      t = c;
      COND_NC:     t = ~c;
      COND_S:      t = s;
      COND_NS:     t = ~s;
      default:     t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [ALU_OP_BITS-1:0] alu_op(input logic [INSTR_BITS-1:0] ins);
    return ins[ALU_OP_LSB +: ALU_OP_BITS];
  endfunction

endpackage

// File: rtl/slurm_cpu_bus_fsm.sv
// Memory/port bus handshake: request registers, wait counter and timeout.
module slurm_cpu_bus_fsm
  import slurm_cpu_execute_hs_pkg::*;
#(
  parameter int unsigned BITS         = 16,
  parameter int unsigned ADDRESS_BITS = 16,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic                    start_wr,
  input  logic                    start_port,
  input  logic [ADDRESS_BITS-1:0] start_addr,
  input  logic [BITS-1:0]         start_wdata,
  input  logic                    bus_ack,
  input  logic [BITS-1:0]         bus_rdata,
  output logic                    bus_req,
  output logic                    bus_is_port,
  output logic                    bus_wr,
  output logic [ADDRESS_BITS-1:0] bus_addr,
  output logic [BITS-1:0]         bus_wdata,
  output logic [BITS-1:0]         load_data,
  output logic                    load_data_valid,
  output logic                    bus_error,
  output logic                    stall
);

  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [WAIT_CNT_BITS-1:0] LAST_WAIT = WAIT_CNT_BITS'(MAX_WAIT - 1);

  bus_state_t               state;
  logic [WAIT_CNT_BITS-1:0] wait_cnt;

  assign stall = (state == ST_WAIT);

  // Request capture in IDLE, hold until ack or timeout in WAIT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= ST_IDLE;
      wait_cnt        <= '0;
      bus_req         <= 1'b0;
      bus_is_port     <= 1'b0;
      bus_wr          <= 1'b0;
      bus_addr        <= '0;
      bus_wdata       <= '0;
      load_data       <= '0;
      load_data_valid <= 1'b0;
      bus_error       <= 1'b0;
    end else begin
      load_data_valid <= 1'b0;
      bus_error       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bus_req     <= 1'b1;
            bus_is_port <= start_port;
            bus_wr      <= start_wr;
            bus_addr    <= start_addr;
            bus_wdata   <= start_wr ? start_wdata : '0;
            wait_cnt    <= '0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= ST_IDLE;
            if (!bus_wr) begin
              load_data       <= bus_rdata;
              load_data_valid <= 1'b1;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            bus_req   <= 1'b0;
            bus_error <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_CNT_BITS'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/slurm_cpu_execute_hs.sv
// Execute stage: ALU operand registers, branch resolution, interrupt enable
// and the handshaked memory/port bus.
module slurm_cpu_execute_hs
  import slurm_cpu_execute_hs_pkg::*;
#(
  parameter int unsigned BITS         = 16,
  parameter int unsigned ADDRESS_BITS = 16,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [BITS-1:0]         instruction,
  input  logic                    is_executing,
  input  logic                    Z,
  input  logic                    C,
  input  logic                    S,
  input  logic [BITS-1:0]         regA,
  input  logic [BITS-1:0]         regB,
  input  logic [BITS-1:0]         imm_reg,
  output logic                    bus_req,
  output logic                    bus_is_port,
  output logic                    bus_wr,
  output logic [ADDRESS_BITS-1:0] bus_addr,
  output logic [BITS-1:0]         bus_wdata,
  input  logic                    bus_ack,
  input  logic [BITS-1:0]         bus_rdata,
  output logic [BITS-1:0]         load_data,
  output logic                    load_data_valid,
  output logic                    bus_error,
  output logic                    stall,
  output logic [ALU_OP_BITS-1:0]  aluOp,
  output logic [BITS-1:0]         aluA,
  output logic [BITS-1:0]         aluB,
  output logic                    load_pc,
  output logic [ADDRESS_BITS-1:0] new_pc,
  output logic                    int_en
);

  ins_dec_t                dec;
  logic                    advance;
  logic [ADDRESS_BITS-1:0] mem_addr;

  assign dec      = ins_decode(instruction[INSTR_BITS-1:0]);
  assign advance  = is_executing && !stall;
  assign mem_addr = ADDRESS_BITS'(regB + imm_reg);

  // ALU operand/opcode registers advance only with the pipeline.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      aluOp <= '0;
      aluA  <= '0;
      aluB  <= '0;
    end else if (advance) begin
      aluA  <= regA;
      aluB  <= dec.alu_imm ? imm_reg : regB;
      aluOp <= dec.is_alu ? alu_op(instruction[INSTR_BITS-1:0]) : '0;
    end
  end

  // Interrupt enable flag, changed only by an advancing enable/disable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      int_en <= 1'b0;
    end else if (advance) begin
      if (dec.int_on) begin
        int_en <= 1'b1;
      end else if (dec.int_off) begin
        int_en <= 1'b0;
      end
    end
  end

  // Branch/return resolution, combinational so fetch can redirect this cycle.
  always_comb begin
    load_pc = 1'b0;
    new_pc  = ADDRESS_BITS'(regA + imm_reg);
    if (dec.is_ret) begin
      new_pc = ADDRESS_BITS'(regA);
    end
    if (advance && (dec.is_ret ||
        (dec.is_branch && branch_taken(instruction[2:0], Z, C, S)))) begin
      load_pc = 1'b1;
    end
  end

  slurm_cpu_bus_fsm #(
    .BITS         (BITS),
    .ADDRESS_BITS (ADDRESS_BITS),
    .MAX_WAIT     (MAX_WAIT)
  ) u_bus_fsm (
    .CLK             (CLK),
    .RST             (RST),
    .start           (is_executing && dec.is_mem),
    .start_wr        (dec.mem_wr),
    .start_port      (dec.mem_port),
    .start_addr      (mem_addr),
    .start_wdata     (regA),
    .bus_ack         (bus_ack),
    .bus_rdata       (bus_rdata),
    .bus_req         (bus_req),
    .bus_is_port     (bus_is_port),
    .bus_wr          (bus_wr),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .load_data       (load_data),
    .load_data_valid (load_data_valid),
    .bus_error       (bus_error),
    .stall           (stall)
  );

endmodule

// File: tb/tb_slurm_cpu_execute_hs.sv
// Randomized bench for slurm_cpu_execute_hs against a transaction-level model,
// preceded by directed scenarios with hand-computed expectations.
module tb_slurm_cpu_execute_hs;

  localparam int MAX_WAIT = 15;

  logic        CLK;
  logic        RST;
  logic [15:0] instruction;
  logic        is_executing;
  logic        Z, C, S;
  logic [15:0] regA, regB, imm_reg;
  logic        bus_req, bus_is_port, bus_wr;
  logic [15:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;
  logic [15:0] load_data;
  logic        load_data_valid, bus_error, stall;
  logic [4:0]  aluOp;
  logic [15:0] aluA, aluB;
  logic        load_pc;
  logic [15:0] new_pc;
  logic        int_en;

  slurm_cpu_execute_hs #(.BITS(16), .ADDRESS_BITS(16), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST), .instruction(instruction), .is_executing(is_executing),
    .Z(Z), .C(C), .S(S), .regA(regA), .regB(regB), .imm_reg(imm_reg),
    .bus_req(bus_req), .bus_is_port(bus_is_port), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .load_data(load_data), .load_data_valid(load_data_valid),
    .bus_error(bus_error), .stall(stall), .aluOp(aluOp), .aluA(aluA), .aluB(aluB),
    .load_pc(load_pc), .new_pc(new_pc), .int_en(int_en)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, exe, z, c, s, ack;
    logic [15:0] ins, ra, rb, imm, rdata;
  } stim_t;

  stim_t nx;
  int checks   = 0;
  int failures = 0;

  // Model of the architectural state: an outstanding transaction and its age.
  logic        m_busy;
  int          m_waited;
  logic        m_req, m_port, m_wr, m_ldv, m_err, m_inten;
  logic [15:0] m_addr, m_wdata, m_ld, m_alua, m_alub;
  logic [4:0]  m_aluop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cls(input logic [15:0] ins);
    return int'(ins[15:12]);
  endfunction

  function automatic logic cond_ok(input logic [15:0] ins, input logic z, input logic c,
                                   input logic s);
    case (ins[2:0])
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return c;
      3'd4: return !c;
      3'd5: return s;
      3'd6: return !s;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] mk(input int k, input logic [11:0] rest);
    logic [3:0] hi;
    hi = 4'(k);
    return {hi, rest};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_waited = 0; m_req = 0; m_port = 0; m_wr = 0; m_ldv = 0; m_err = 0;
    m_inten = 0; m_addr = 0; m_wdata = 0; m_ld = 0; m_alua = 0; m_alub = 0; m_aluop = 0;
  endtask

  task automatic model_step();
    int k;
    k = cls(nx.ins);
    if (nx.rst) begin
      model_reset();
      return;
    end
    if (nx.exe && !m_busy) begin
      m_alua  = nx.ra;
      m_alub  = (k == 3) ? nx.imm : nx.rb;
      m_aluop = (k >= 1 && k <= 3) ? nx.ins[11:7] : 5'd0;
      if (k == 11) m_inten = 1'b1;
      if (k == 12) m_inten = 1'b0;
    end
    m_ldv = 0;
    m_err = 0;
    if (!m_busy) begin
      if (nx.exe && k >= 7 && k <= 10) begin
        m_busy = 1; m_waited = 0; m_req = 1;
        m_wr   = (k == 8 || k == 10);
        m_port = (k == 9 || k == 10);
        m_addr = 16'(nx.rb + nx.imm);
        m_wdata = m_wr ? nx.ra : 16'h0;
      end
    end else begin
      m_waited++;
      if (nx.ack) begin
        m_busy = 0; m_req = 0;
        if (!m_wr) begin m_ld = nx.rdata; m_ldv = 1; end
      end else if (m_waited == MAX_WAIT) begin
        m_busy = 0; m_req = 0; m_err = 1;
      end
    end
  endtask

  // One clock: drive at negedge, compare every output with the model, advance model.
  task automatic tick();
    int   k;
    logic exp_lpc;
    @(negedge CLK);
    RST = nx.rst; is_executing = nx.exe; instruction = nx.ins;
    regA = nx.ra; regB = nx.rb; imm_reg = nx.imm;
    Z = nx.z; C = nx.c; S = nx.s; bus_ack = nx.ack; bus_rdata = nx.rdata;
    if (nx.rst) model_reset();
    #1;
    k = cls(nx.ins);
    exp_lpc = !nx.rst && nx.exe && !m_busy &&
              ((k == 4 && cond_ok(nx.ins, nx.z, nx.c, nx.s)) || k == 5 || k == 6);
    chk("stall", stall, m_busy);
    chk("bus_req", bus_req, m_req);
    chk("bus_error", bus_error, m_err);
    chk("load_data_valid", load_data_valid, m_ldv);
    chk("aluOp", aluOp, m_aluop);
    chk("aluA", aluA, m_alua);
    chk("aluB", aluB, m_alub);
    chk("int_en", int_en, m_inten);
    chk("load_pc", load_pc, exp_lpc);
    if (m_req) begin
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_wr", bus_wr, m_wr);
      chk("bus_is_port", bus_is_port, m_port);
      chk("bus_wdata", bus_wdata, m_wdata);
    end
    if (m_ldv) chk("load_data", load_data, m_ld);
    if (exp_lpc) chk("new_pc", new_pc, (k == 4) ? 16'(nx.ra + nx.imm) : nx.ra);
    @(posedge CLK);
    model_step();
  endtask

  task automatic idle_stim();
    nx.rst = 0; nx.exe = 0; nx.ins = 16'h0; nx.ra = 0; nx.rb = 0; nx.imm = 0;
    nx.z = 0; nx.c = 0; nx.s = 0; nx.ack = 0; nx.rdata = 0;
  endtask

  initial begin : main
    int n_stall, n_err, n_ldv, ack_mode;
    RST = 1'b1; is_executing = 0; instruction = 0; regA = 0; regB = 0; imm_reg = 0;
    Z = 0; C = 0; S = 0; bus_ack = 0; bus_rdata = 0;
    model_reset();
    idle_stim();

    // Reset state
    nx.rst = 1; tick(); tick();
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_int_en", int_en, 0);
    idle_stim(); tick();

    // Load regB=0x1000 + imm 4, three idle WAIT cycles then ack with 0xBEEF
    nx.exe = 1; nx.ins = mk(7, 12'h000); nx.rb = 16'h1000; nx.imm = 16'h0004; tick();
    #1;
    chk("ld_addr", bus_addr, 16'h1004);
    chk("ld_wr", bus_wr, 0);
    n_stall = stall ? 1 : 0;
    idle_stim();
    for (int i = 0; i < 3; i++) begin tick(); #1; if (stall) n_stall++; end
    nx.ack = 1; nx.rdata = 16'hBEEF; tick(); #1;
    chk("ld_stall_cycles", n_stall, 4);
    chk("ld_valid", load_data_valid, 1);
    chk("ld_data", load_data, 16'hBEEF);
    chk("ld_stall_after", stall, 0);
    idle_stim(); tick(); #1;
    chk("ld_valid_one_cycle", load_data_valid, 0);

    // Poke regA=0x55AA to port 0x0010, ack on second WAIT cycle
    nx.exe = 1; nx.ins = mk(10, 12'h000); nx.ra = 16'h55AA; nx.rb = 16'h0010; tick(); #1;
    chk("poke_port", bus_is_port, 1);
    chk("poke_wr", bus_wr, 1);
    chk("poke_wdata", bus_wdata, 16'h55AA);
    idle_stim(); tick();
    nx.ack = 1; nx.rdata = 16'h1234; tick(); #1;
    chk("poke_no_valid", load_data_valid, 0);
    chk("poke_done", bus_req, 0);

    // Load with no ack: timeout after MAX_WAIT WAIT cycles
    idle_stim(); nx.exe = 1; nx.ins = mk(7, 12'h000); nx.rb = 16'h2000; tick(); #1;
    n_stall = stall ? 1 : 0; n_err = 0; n_ldv = 0;
    idle_stim();
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      if (stall) n_stall++;
      if (bus_error) n_err++;
      if (load_data_valid) n_ldv++;
    end
    chk("to_stall_cycles", n_stall, MAX_WAIT);
    chk("to_err_pulses", n_err, 1);
    chk("to_no_valid", n_ldv, 0);
    chk("to_stall_drop", stall, 0);

    // Ack coincident with the last WAIT cycle wins over timeout
    nx.exe = 1; nx.ins = mk(7, 12'h000); nx.rb = 16'h3000; tick();
    idle_stim();
    for (int i = 0; i < MAX_WAIT - 1; i++) tick();
    nx.ack = 1; nx.rdata = 16'hC0DE; tick(); #1;
    chk("late_ack_valid", load_data_valid, 1);
    chk("late_ack_no_err", bus_error, 0);
    chk("late_ack_data", load_data, 16'hC0DE);
    idle_stim(); tick(); #1;
    chk("late_ack_no_err_next", bus_error, 0);

    // Taken branch wraps: 0xFFF0 + 0x0020 -> 0x0010
    nx.exe = 1; nx.ins = mk(4, 12'h000); nx.ra = 16'hFFF0; nx.imm = 16'h0020; tick(); #1;
    chk("br_load_pc", load_pc, 1);
    chk("br_new_pc", new_pc, 16'h0010);
    // Same branch during a stall is suppressed
    nx.ins = mk(7, 12'h000); nx.rb = 16'h0040; tick();
    nx.ins = mk(4, 12'h000); nx.ra = 16'hFFF0; nx.imm = 16'h0020; tick(); #1;
    chk("br_stalled", load_pc, 0);

    // Asynchronous reset in mid-WAIT
    #3 RST = 1'b1; #1;
    chk("arst_stall", stall, 0);
    chk("arst_req", bus_req, 0);
    chk("arst_addr", bus_addr, 0);
    chk("arst_aluA", aluA, 0);
    model_reset();
    idle_stim(); nx.rst = 1; tick();
    nx.rst = 0; tick(); tick(); #1;
    chk("arst_no_err", bus_error, 0);
    chk("arst_no_valid", load_data_valid, 0);

    // Interrupt enable then disable
    nx.exe = 1; nx.ins = mk(11, 12'h000); tick(); #1;
    chk("int_on", int_en, 1);
    nx.ins = mk(12, 12'h000); tick(); #1;
    chk("int_off", int_en, 0);

    // Randomized traffic; ack probability alternates so timeouts also occur
    ack_mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) ack_mode = $urandom_range(0, 1);
      nx.rst   = ($urandom_range(0, 499) == 0);
      nx.exe   = ($urandom_range(0, 3) != 0);
      nx.ins   = mk($urandom_range(0, 15), 12'($urandom));
      nx.ra    = 16'($urandom);
      nx.rb    = 16'($urandom);
      nx.imm   = 16'($urandom);
      nx.rdata = 16'($urandom);
      nx.z = 1'($urandom); nx.c = 1'($urandom); nx.s = 1'($urandom);
      nx.ack = (ack_mode == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slurm_cpu_execute_hs.md
SLURM_CPU_EXECUTE_HS -- requirements
Module: slurm_cpu_execute_hs

Interface
REQ-001 Parameter BITS, 16, data path width.
REQ-002 Parameter ADDRESS_BITS, 16, memory/port address width.
REQ-003 Parameter MAX_WAIT, 15, bus-wait cycles before timeout; legal range 1..255.
REQ-004 Ports:
- CLK  in  1  single clock, all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- instruction  in  BITS  instruction in pipeline slot 2.
- is_executing  in  1  slot 2 instruction is valid.
- Z, C, S  in  1 each  ALU flags, used for branch evaluation.
- regA, regB, imm_reg  in  BITS each  operands and immediate.
- bus_req  out  1  memory/port request.
- bus_is_port  out  1  1 = port space, 0 = memory.
- bus_wr  out  1  1 = write, 0 = read.
- bus_addr  out  ADDRESS_BITS  request address.
- bus_wdata  out  BITS  write data.
- bus_ack  in  1  request completed.
- bus_rdata  in  BITS  read data, valid with bus_ack.
- load_data  out  BITS  captured read data.
- load_data_valid  out  1  one-cycle pulse with load_data.
- bus_error  out  1  one-cycle pulse on timeout.
- stall  out  1  hold pipeline.
- aluOp  out  5  registered ALU operation.
- aluA, aluB  out  BITS each  registered ALU operands.
- load_pc  out  1  branch/ret taken.
- new_pc  out  ADDRESS_BITS  branch target.
- int_en  out  1  interrupt enable flag, registered.

Function
REQ-005 Instruction classes (ALU single, ALU reg-reg, ALU reg-imm, branch, ret/iret, load/store, peek/poke, int enable/disable) come from the shared decode package.
REQ-006 ALU registers: when is_executing and !stall, load aluA=regA, aluB=regB (imm_reg for reg-imm), aluOp from instruction (0 for non-ALU); otherwise hold.
REQ-007 Branch: combinational; load_pc=1, new_pc=regA+imm_reg (modulo 2^ADDRESS_BITS) when taken; ret/iret gives new_pc=regA; load_pc forced 0 when !is_executing or stall.
REQ-008 FSM states IDLE, WAIT.
REQ-009 IDLE: is_executing with load/store or peek/poke registers bus_addr=regB+imm_reg (wrap), bus_wr, bus_is_port, bus_wdata=regA (writes) or 0 (reads), sets bus_req=1 -> WAIT next cycle.
REQ-010 WAIT: bus_req and all bus_* outputs held stable until bus_ack.
REQ-011 bus_ack in WAIT: bus_req=0 and -> IDLE next cycle; for reads, load_data=bus_rdata and load_data_valid=1 for exactly that next cycle.
REQ-012 Wait counter cleared on entry to WAIT, increments per WAIT cycle; reaching MAX_WAIT without ack -> bus_error pulse 1 cycle, -> IDLE, no load_data_valid.
REQ-013 bus_ack and final timeout count in same cycle: ack wins, no bus_error.
REQ-014 bus_ack in IDLE ignored.
REQ-015 stall=1 in every cycle state==WAIT (ack cycle included); 0 in IDLE.
REQ-016 int_en set by enable, cleared by disable, only when is_executing and !stall; otherwise held.

Reset
REQ-017 RST=1 asynchronously forces IDLE, counter 0, and zeros all registered outputs: aluOp, aluA, aluB, bus_*, load_data, load_data_valid, bus_error, int_en.
REQ-018 Reset during WAIT abandons the transaction; no error or data pulse follows.

Structure
REQ-019 Shared package holds instruction-class casex constants, decode functions, state encodings, and the ALU opcode width (5).
REQ-020 Single sub-module slurm_cpu_bus_fsm contains the FSM, wait counter and bus registers; the ALU, branch and int_en logic stay in the top level.

Verification
REQ-021 Load from regB=0x1000, imm=0x0004; ack after 3 cycles with rdata=0xBEEF -> bus_addr=0x1004, stall 4 cycles, load_data_valid 1 cycle with 0xBEEF.
REQ-022 Poke with regA=0x55AA, regB=0x0010, imm=0; ack after 1 cycle -> bus_is_port=1, bus_wr=1, bus_wdata=0x55AA, no load_data_valid.
REQ-023 Load with no ack -> bus_error pulse after MAX_WAIT (15) WAIT cycles, return to IDLE, stall drops.
REQ-024 Ack coincident with 15th WAIT cycle -> completion, no bus_error.
REQ-025 Taken branch with regA=0xFFF0, imm=0x0020 -> load_pc=1, new_pc=0x0010; the same branch presented during stall -> load_pc=0.
REQ-026 RST asserted in mid-WAIT -> all outputs 0 immediately; enable then disable instructions -> int_en goes 1 then 0.
